// File: rtl/dmem_port_arbiter.sv
//------------------------------------------------------------------------------
// dmem_port_arbiter: CPU/DMA arbiter for the shared 3-lane data memory.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_port_arbiter #(
  parameter int AW         = 10,
  parameter int LW         = 18,
  parameter int LANES      = 3,
  parameter int MAX_BURST  = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  // CPU (MEM stage) port
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [AW-1:0]         cpu_a1,
  input  logic [AW-1:0]         cpu_a2,
  input  logic [AW-1:0]         cpu_a3,
  input  logic [LANES*LW-1:0]   cpu_wd,
  output logic                  cpu_stall,
  output logic [LANES*LW-1:0]   cpu_rd,
  output logic                  cpu_rvalid,
  // DMA (image loader) port
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic                  dma_last,
  input  logic [AW-1:0]         dma_addr,
  input  logic [LANES*LW-1:0]   dma_wd,
  output logic                  dma_gnt,
  output logic [LANES*LW-1:0]   dma_rd,
  output logic                  dma_rvalid,
  // Memory side
  output logic [AW-1:0]         mem_a1,
  output logic [AW-1:0]         mem_a2,
  output logic [AW-1:0]         mem_a3,
  output logic [LANES*LW-1:0]   mem_wd,
  output logic                  mem_we,
  input  logic [LANES*LW-1:0]   mem_rd
);

  localparam logic [7:0] C_STARVE_MAX = 8'(STARVE_MAX);
  localparam logic [8:0] C_MAX_BURST  = 9'(MAX_BURST);

  typedef enum logic [0:0] {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } state_e;

  state_e     st_q, st_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       rd_valid_q, rd_valid_d;
  logic       rd_owner_q, rd_owner_d;

  logic       cpu_gnt;
  logic [8:0] beat_inc;
  logic       burst_end;

  assign beat_inc  = {1'b0, beat_cnt_q} + 9'd1;
  assign burst_end = dma_last | (beat_inc >= C_MAX_BURST);

  // Grant: CPU has priority in S_CPU unless the DMA has been starved too long;
  // inside a locked burst the DMA keeps the port while it keeps requesting.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    case (st_q)
      S_DMA: begin
        dma_gnt = dma_req;
        cpu_gnt = cpu_req & ~dma_req;
      end
      default: begin
        cpu_gnt = cpu_req & (starve_cnt_q != C_STARVE_MAX);
        dma_gnt = dma_req & ~cpu_gnt;
      end
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    st_d       = st_q;
    beat_cnt_d = beat_cnt_q;
    case (st_q)
      S_CPU: begin
        if (dma_gnt && !dma_last) begin
          st_d       = S_DMA;
          beat_cnt_d = 8'd1;
        end
      end
      S_DMA: begin
        if (!dma_req || burst_end) begin
          st_d       = S_CPU;
          beat_cnt_d = 8'd0;
        end else begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      default: begin
        st_d       = S_CPU;
        beat_cnt_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (dma_gnt || !dma_req) begin
      starve_cnt_d = 8'd0;
    end else if (starve_cnt_q != C_STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  // One read is in flight at most; the owner bit steers its valid strobe.
  assign rd_valid_d = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
  assign rd_owner_d = dma_gnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q         <= S_CPU;
      beat_cnt_q   <= 8'd0;
      starve_cnt_q <= 8'd0;
      rd_valid_q   <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      st_q         <= st_d;
      beat_cnt_q   <= beat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      rd_valid_q   <= rd_valid_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign cpu_rvalid = rd_valid_q & ~rd_owner_q;
  assign dma_rvalid = rd_valid_q &  rd_owner_q;
  assign cpu_rd     = mem_rd;
  assign dma_rd     = mem_rd;

  // DMA lanes are consecutive words; the additions wrap modulo 2^AW.
  always_comb begin
    mem_a1 = cpu_a1;
    mem_a2 = cpu_a2;
    mem_a3 = cpu_a3;
    mem_wd = cpu_wd;
    if (dma_gnt) begin
      mem_a1 = dma_addr;
      mem_a2 = dma_addr + AW'(1);
      mem_a3 = dma_addr + AW'(2);
      mem_wd = dma_wd;
    end
  end

  assign mem_we = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);

endmodule

`default_nettype wire
